// File: rtl/uart_baud_gen_pkg.sv
// Shared constants for the UART 16x baud tick generator.
// Divisor, fraction and oversample widths used by uart_baud_gen.
package uart_baud_gen_pkg;

    localparam int DIVISOR_WIDTH = 16;
    localparam int FRAC_WIDTH    = 4;
    localparam int OVERSAMPLE    = 16;

endpackage

// File: rtl/uart_baud_gen.sv
// UART 16x-oversample tick generator with 1/16-cycle fractional divisor.
// Ports: i_clk, i_rst (sync, active-high), i_divisor_x16, i_fra_adj_x16,
//        o_baud_x16 (registered one-cycle tick). COUNTER_WIDTH must be >= 17.
module uart_baud_gen
    import uart_baud_gen_pkg::*;
#(
    parameter int COUNTER_WIDTH = 20
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [DIVISOR_WIDTH-1:0] i_divisor_x16,
    input  logic [FRAC_WIDTH-1:0]    i_fra_adj_x16,
    output logic                     o_baud_x16
);

    logic [COUNTER_WIDTH-1:0] cnt;
    logic [COUNTER_WIDTH-1:0] period_q;
    logic [COUNTER_WIDTH-1:0] period_cur;
    logic [FRAC_WIDTH-1:0]    acc;
    logic [FRAC_WIDTH:0]      acc_sum;
    logic                     start;
    logic                     wrap;
    logic                     idle;

    // On the first cycle of a period the length is computed live from the
    // inputs, so the counter can already compare against it; afterwards the
    // latched length is used and input changes wait for the next period.
    always_comb begin
        acc_sum    = {1'b0, acc} + {1'b0, i_fra_adj_x16};
        period_cur = period_q;
        if (start) begin
            period_cur = COUNTER_WIDTH'(i_divisor_x16)
                       + COUNTER_WIDTH'(acc_sum[FRAC_WIDTH]);
        end
        wrap = (cnt == period_cur - COUNTER_WIDTH'(1));
        idle = (i_divisor_x16 == '0);
    end

    // A zero divisor parks the generator exactly as reset does, so the
    // first tick after it becomes nonzero follows reset-release timing.
    always_ff @(posedge i_clk) begin
        if (i_rst || idle) begin
            cnt        <= '0;
            acc        <= '0;
            period_q   <= '0;
            o_baud_x16 <= 1'b0;
            start      <= 1'b1;
        end else begin
            if (start) begin
                period_q <= period_cur;
                acc      <= acc_sum[FRAC_WIDTH-1:0];
            end
            if (wrap) begin
                cnt        <= '0;
                o_baud_x16 <= 1'b1;
                start      <= 1'b1;
            end else begin
                cnt        <= cnt + COUNTER_WIDTH'(1);
                o_baud_x16 <= 1'b0;
                start      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_baud_gen.sv
// Self-checking bench for uart_baud_gen: tick-schedule reference model,
// table of span vectors, directed reset/zero/divisor-change sequences.
module tb_uart_baud_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] div = '0;
    logic [3:0]  fra = '0;
    logic        tick;

    int checks = 0;
    int errors = 0;

    uart_baud_gen #(.COUNTER_WIDTH(20)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_divisor_x16 (div),
        .i_fra_adj_x16 (fra),
        .o_baud_x16    (tick)
    );

    always #10 clk = ~clk;

    // Reference model: schedules the edge number of the next tick when a
    // period starts, using the accumulator rule on plain integers.
    int unsigned edge_n  = 0;
    int unsigned tick_at = 0;
    int          acc_m   = 0;
    bit          in_per  = 0;
    bit          exp_tick = 0;
    bit          chk_en  = 0;

    always @(posedge clk) begin
        int p;
        edge_n   = edge_n + 1;
        exp_tick = 0;
        if (rst || div == 0) begin
            acc_m  = 0;
            in_per = 0;
        end else begin
            if (!in_per) begin
                p       = int'(div) + ((acc_m + int'(fra)) >= 16 ? 1 : 0);
                acc_m   = (acc_m + int'(fra)) % 16;
                tick_at = edge_n + p - 1;
                in_per  = 1;
            end
            if (edge_n == tick_at) begin
                exp_tick = 1;
                in_per   = 0;
            end
        end
        chk_en = 1;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            checks = checks + 1;
            if (tick !== exp_tick) begin
                errors = errors + 1;
                $display("FAIL model t=%0t got %b expected %b",
                         $time, tick, exp_tick);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    // Counts negedges until the tick is seen; -1 on timeout.
    task automatic wait_tick(input int budget, output int cyc);
        cyc = -1;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            if (tick === 1'b1) begin
                cyc = k;
                break;
            end
        end
    endtask

    task automatic do_reset(input logic [15:0] d, input logic [3:0] f);
        @(negedge clk);
        rst = 1'b1;
        div = d;
        fra = f;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic [15:0] d;
        logic [3:0]  f;
        int          first;
        int          span16;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int c;
        int sum;
        int hi;

        vecs[0] = '{16'd27, 4'd8,  27, 440};
        vecs[1] = '{16'd27, 4'd0,  27, 432};
        vecs[2] = '{16'd27, 4'd15, 27, 447};
        vecs[3] = '{16'd4,  4'd0,  4,  64};
        vecs[4] = '{16'd1,  4'd0,  1,  16};
        vecs[5] = '{16'd1,  4'd1,  1,  17};
        vecs[6] = '{16'd2,  4'd15, 2,  47};
        vecs[7] = '{16'd3,  4'd7,  3,  55};

        repeat (3) @(negedge clk);
        chk("reset_low", int'(tick), 0);

        foreach (vecs[i]) begin
            do_reset(vecs[i].d, vecs[i].f);
            wait_tick(200, c);
            chk($sformatf("first_%0d", i), c, vecs[i].first);
            sum = 0;
            for (int j = 0; j < 16; j++) begin
                wait_tick(200, c);
                sum = sum + c;
            end
            chk($sformatf("span16_%0d", i), sum, vecs[i].span16);
        end

        // Alternating 27/28 pattern.
        do_reset(16'd27, 4'd8);
        wait_tick(100, c);
        wait_tick(100, c);
        chk("alt_28", c, 28);
        wait_tick(100, c);
        chk("alt_27", c, 27);

        // Reset mid-period: nothing during or right after, then restart.
        repeat (10) @(negedge clk);
        rst = 1'b1;
        hi = 0;
        repeat (3) begin
            @(negedge clk);
            if (tick === 1'b1) hi = hi + 1;
        end
        rst = 1'b0;
        wait_tick(100, c);
        chk("rst_window_ticks", hi, 0);
        chk("rst_first", c, 27);
        wait_tick(100, c);
        chk("rst_second", c, 28);

        // Zero divisor holds output low, then div=4 ticks every 4 cycles.
        div = 16'd0;
        fra = 4'd0;
        hi  = 0;
        repeat (500) begin
            @(negedge clk);
            if (tick === 1'b1) hi = hi + 1;
        end
        chk("zero_div_ticks", hi, 0);
        div = 16'd4;
        wait_tick(100, c);
        chk("zero_resume_first", c, 4);
        for (int j = 0; j < 3; j++) begin
            wait_tick(100, c);
            chk($sformatf("zero_resume_%0d", j), c, 4);
        end

        // Divisor change mid-period takes effect from the next period.
        div = 16'd27;
        wait_tick(100, c);
        wait_tick(100, c);
        repeat (10) @(negedge clk);
        div = 16'd30;
        wait_tick(100, c);
        chk("chg_old_rest", c, 17);
        wait_tick(100, c);
        chk("chg_new", c, 30);

        // Randomized traffic against the model.
        for (int r = 0; r < 60; r++) begin
            @(negedge clk);
            if ($urandom_range(0, 9) == 0) div = 16'd0;
            else div = 16'($urandom_range(1, 40));
            fra = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) begin
                rst = 1'b1;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                rst = 1'b0;
            end
            repeat ($urandom_range(1, 120)) @(negedge clk);
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_baud_gen.md
UART_BAUD_GEN -- requirements
Module: uart_baud_gen

Interface
REQ-001 Parameter COUNTER_WIDTH, default 20, width of the internal clock-cycle counter; SHALL be >= 17.
REQ-002 i_clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 i_rst  input  1  reset, synchronous, active-high.
REQ-004 i_divisor_x16  input  16  integer part of clk/(16*baud), in clock cycles.
REQ-005 i_fra_adj_x16  input  4  fractional part of clk/(16*baud), in 1/16 cycle.
REQ-006 o_baud_x16  output  1  registered 16x-oversample tick, one i_clk cycle wide.

Function
REQ-007 SHALL produce ticks whose average period is (i_divisor_x16 + i_fra_adj_x16/16) clocks; every 16 consecutive ticks SHALL span exactly 16*i_divisor_x16 + i_fra_adj_x16 clocks.
REQ-008 Fraction: 4-bit accumulator ACC; at each period start, if ACC + i_fra_adj_x16 >= 16 the period SHALL be i_divisor_x16+1 clocks, else i_divisor_x16; ACC SHALL then become (ACC + i_fra_adj_x16) mod 16.
REQ-009 Counter SHALL count 0..P-1 for the current period length P; o_baud_x16 SHALL be high in exactly the cycle after the counter reaches P-1, and the counter SHALL wrap to 0 at that point.
REQ-010 First tick after reset release SHALL occur on the P-th rising edge after reset is deasserted (P computed with ACC=0).
REQ-011 i_divisor_x16 and i_fra_adj_x16 SHALL be sampled at each period start; changes mid-period SHALL take effect from the next period.
REQ-012 i_divisor_x16 = 0: o_baud_x16 SHALL stay low, counter and ACC held at 0; resumes per REQ-010 timing once nonzero.
REQ-013 i_divisor_x16 = 1 with i_fra_adj_x16 = 0: o_baud_x16 SHALL be high every cycle.
REQ-014 i_fra_adj_x16 = 0 SHALL give a constant period of exactly i_divisor_x16 clocks.
REQ-015 Counter arithmetic SHALL be unsigned at COUNTER_WIDTH bits; no overflow for any 16-bit divisor + 1.

Reset
REQ-016 While i_rst is high at a rising edge: counter <= 0, ACC <= 0, o_baud_x16 <= 0, period-start flag set.
REQ-017 Reset asserted mid-period SHALL abort the period; no tick SHALL be emitted during or in the cycle after reset.

Structure
REQ-018 Shared package SHALL hold DIVISOR_WIDTH = 16, FRAC_WIDTH = 4 and OVERSAMPLE = 16.
REQ-019 Single flat module; no sub-modules.

Verification (T_CLK = 20 ns)
REQ-020 div=27, fra=8, release reset -> tick intervals alternate 540/560 ns; 16 ticks span 8800 ns.
REQ-021 div=27, fra=0 -> every interval 540 ns; 16 ticks span 8640 ns.
REQ-022 div=27, fra=15 -> 15 of every 16 intervals 560 ns, one 540 ns; 16 ticks span 8940 ns.
REQ-023 div=0 for 10 us -> o_baud_x16 never high; then div=4, fra=0 -> first tick 80 ns after change takes effect, then every 80 ns.
REQ-024 div=27, fra=8, assert i_rst for 3 cycles mid-period -> no tick in that window; first tick 540 ns after deassertion; pattern restarts at 540 ns.
REQ-025 Change div 27->30 mid-period -> current period completes at old length; next interval 600 ns.
